pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central control/hazard sequencer for the 5-stage RV64 pipeline. Decodes the ID-stage
//  instruction into datapath controls, including ImmSrc for the immediate generator
//  (00 I, 01 S, 10 B). Tracks the instruction in EX to detect load-use hazards, and
//  flushes on taken branches. Freezes the whole pipe while the data memory is busy.
// PARAMETERS
//  MAX_WAIT  16  cycles in MEM_WAIT before forced exit and a mem_timeout pulse (>=1)
//  CNT_W     32  width of the performance counters (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk             in   1      single clock, all state on rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  instr_d         in   32     instruction in ID
//  valid_d         in   1      instr_d is a real instruction (0 = bubble)
//  branch_taken_e  in   1      branch in EX resolved taken
//  mem_req_m       in   1      load/store in MEM is requesting data memory
//  mem_ready       in   1      data memory completes the request this cycle
//  imm_src_d       out  2      ImmSrc to the immediate generator
//  reg_write_d     out  1      ID instruction writes rd
//  mem_read_d      out  1      ID instruction is a load
//  mem_write_d     out  1      ID instruction is a store
//  branch_d        out  1      ID instruction is a branch
//  alu_src_d       out  1      ALU operand B = immediate
//  illegal_d       out  1      valid_d with an unsupported opcode
//  stall_f         out  1      hold PC
//  stall_d         out  1      hold IF/ID
//  stall_em        out  1      hold ID/EX, EX/MEM, MEM/WB
//  flush_d         out  1      clear IF/ID to bubble
//  flush_e         out  1      clear ID/EX to bubble
//  mem_timeout     out  1      one-cycle pulse on forced MEM_WAIT exit
//  stall_cnt       out  CNT_W  cycles with stall_f=1
//  flush_cnt       out  CNT_W  cycles with flush_e=1
// BEHAVIOUR
//  Decode (combinational, opcode = instr_d[6:0]; all controls 0 when valid_d=0):
//   0000011 load: imm 00, rw 1, mr 1, alu_src 1 | 0010011 I-ALU: imm 00, rw 1, alu_src 1
//   0100011 store: imm 01, mw 1, alu_src 1      | 1100011 branch: imm 10, br 1
//   0110011 R-type: imm 00, rw 1                 | other: all 0, illegal_d=1
//   rs1 is used by all legal opcodes; rs2 is used by store, branch and R-type.
//  EX tracker regs rd_e[4:0], memread_e: load on each edge unless stall_em=1.
//   If flush_e=1 they load 0; otherwise they load instr_d[11:7] and mem_read_d.
//  FSM states RUN, MEM_WAIT; wait counter wcnt.
//   RUN -> MEM_WAIT when mem_req_m && !mem_ready; wcnt <= 1.
//   MEM_WAIT -> RUN when mem_ready, or when wcnt == MAX_WAIT. The latter asserts mem_timeout that cycle.
//   Otherwise wcnt increments.
//  Hazard outputs (combinational, same cycle), priority high to low:
//   1 memory freeze (state==MEM_WAIT, or RUN with mem_req_m && !mem_ready): stall_f=stall_d=stall_em=1.
//     All flushes 0; branch_taken_e and load-use are ignored while frozen.
//   2 branch_taken_e: flush_d=flush_e=1, stalls 0.
//   3 load-use (memread_e && rd_e!=0 && rd_e matches a used rs1/rs2 of a legal valid_d):
//     stall_f=stall_d=1 and flush_e=1, so exactly one bubble is inserted.
//   4 otherwise all stall/flush 0.
//  Reset (async, rst_n=0): state RUN, wcnt 0, rd_e 0, memread_e 0, counters 0, mem_timeout 0.
//   With idle inputs all outputs are 0. Reset mid-MEM_WAIT returns to RUN immediately.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: stall_cnt/flush_cnt increment once per cycle of stall_f/flush_e.
//   They wrap modulo 2^CNT_W and clear on reset.
//  Not defined: counter logic is omitted and stall_cnt/flush_cnt are tied to 0. The ports always exist.
// TESTING
//  Load x5 then "add x6,x5,x1" in ID -> one cycle stall_f=stall_d=flush_e=1, then flows. Same with rd=x0 -> no stall.
//  branch_taken_e=1 while load-use is also true -> flush_d=flush_e=1, stall_f=0.
//  mem_req_m=1 with mem_ready low for 3 cycles -> stall_em=1 for 4 cycles, back in RUN after mem_ready.
//  mem_ready never asserted with MAX_WAIT=16 -> mem_timeout pulse on the 16th MEM_WAIT cycle, then RUN.
//  instr_d store/branch/I/R/opcode 1111111 -> imm_src 01/10/00/00, illegal_d only for 1111111.
//  PIPE_CTRL_PERF_EN set, 5 stall + 2 flush cycles -> stall_cnt=5, flush_cnt=2; assert rst_n mid-wait -> both 0, FSM RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Control decode and hazard sequencer for the 5-stage RV64 pipeline.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             branch_taken_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       imm_src_d,
  output logic             reg_write_d,
  output logic             mem_read_d,
  output logic             mem_write_d,
  output logic             branch_d,
  output logic             alu_src_d,
  output logic             illegal_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_em,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [WCNT_W-1:0]   w_wcnt_next;
  logic [4:0]          r_rd_e;
  logic                r_memread_e;

  logic [6:0]          w_opcode;
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic                w_legal;
  logic                w_use_rs2;
  logic                w_freeze;
  logic                w_load_use;
  logic                w_unused;

  assign w_opcode = instr_d[6:0];
  assign w_rs1    = instr_d[19:15];
  assign w_rs2    = instr_d[24:20];
  assign w_unused = ^{instr_d[31:25], instr_d[14:12]};

  always_comb begin
    imm_src_d   = 2'b00;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    alu_src_d   = 1'b0;
    illegal_d   = 1'b0;
    w_legal     = 1'b0;
    w_use_rs2   = 1'b0;
    if (valid_d) begin
      w_legal = 1'b1;
      case (w_opcode)
        OP_LOAD: begin
          reg_write_d = 1'b1;
          mem_read_d  = 1'b1;
          alu_src_d   = 1'b1;
        end
        OP_ALUI: begin
          reg_write_d = 1'b1;
          alu_src_d   = 1'b1;
        end
        OP_STORE: begin
          imm_src_d   = 2'b01;
          mem_write_d = 1'b1;
          alu_src_d   = 1'b1;
          w_use_rs2   = 1'b1;
        end
        OP_BRANCH: begin
          imm_src_d   = 2'b10;
          branch_d    = 1'b1;
          w_use_rs2   = 1'b1;
        end
        OP_RTYPE: begin
          reg_write_d = 1'b1;
          w_use_rs2   = 1'b1;
        end
        default: begin
          illegal_d = 1'b1;
          w_legal   = 1'b0;
        end
      endcase
    end
  end

  // rd_e==0 never hazards: x0 is hardwired and needs no forwarding.
  assign w_load_use = r_memread_e && (r_rd_e != 5'd0) && w_legal &&
                      ((r_rd_e == w_rs1) || (w_use_rs2 && (r_rd_e == w_rs2)));
  assign w_freeze   = (r_state == S_MEM_WAIT) || (mem_req_m && !mem_ready);

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    mem_timeout  = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_em     = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_req_m && !mem_ready) begin
          w_state_next = S_MEM_WAIT;
          w_wcnt_next  = WCNT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_next = S_RUN;
          w_wcnt_next  = '0;
        end else if (r_wcnt == WCNT_MAX) begin
          w_state_next = S_RUN;
          w_wcnt_next  = '0;
          mem_timeout  = 1'b1;
        end else begin
          w_wcnt_next  = r_wcnt + WCNT_W'(1);
        end
      end
      default: w_state_next = S_RUN;
    endcase
    // A busy memory freezes everything, so branch and load-use wait their turn.
    if (w_freeze) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_em = 1'b1;
    end else if (branch_taken_e) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
    end else if (w_load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      flush_e  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_e      <= 5'd0;
      r_memread_e <= 1'b0;
    end else if (!stall_em) begin
      if (flush_e) begin
        r_rd_e      <= 5'd0;
        r_memread_e <= 1'b0;
      end else begin
        r_rd_e      <= instr_d[11:7];
        r_memread_e <= mem_read_d;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_f) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_e) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: decode, load-use, branch flush,
// memory freeze/timeout, async reset and (with PIPE_CTRL_PERF_EN) counters.
module tb_pipe_ctrl;
  localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             branch_taken_e;
  logic             mem_req_m;
  logic             mem_ready;
  logic [1:0]       imm_src_d;
  logic             reg_write_d;
  logic             mem_read_d;
  logic             mem_write_d;
  logic             branch_d;
  logic             alu_src_d;
  logic             illegal_d;
  logic             stall_f;
  logic             stall_d;
  logic             stall_em;
  logic             flush_d;
  logic             flush_e;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_ctrl #(.MAX_WAIT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .imm_src_d(imm_src_d), .reg_write_d(reg_write_d), .mem_read_d(mem_read_d),
    .mem_write_d(mem_write_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
    .illegal_d(illegal_d), .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
    .flush_d(flush_d), .flush_e(flush_e), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {imm_src, reg_write, mem_read, mem_write, branch, alu_src, illegal}
  localparam logic [7:0] C0  = 8'b00_0_0_0_0_0_0;
  localparam logic [7:0] CLD = 8'b00_1_1_0_0_1_0;
  localparam logic [7:0] CI  = 8'b00_1_0_0_0_1_0;
  localparam logic [7:0] CST = 8'b01_0_0_1_0_1_0;
  localparam logic [7:0] CBR = 8'b10_0_0_0_1_0_0;
  localparam logic [7:0] CR  = 8'b00_1_0_0_0_0_0;
  localparam logic [7:0] CIL = 8'b00_0_0_0_0_0_1;
  // haz = {stall_f, stall_d, stall_em, flush_d, flush_e, mem_timeout}
  localparam logic [5:0] H0  = 6'b000000;
  localparam logic [5:0] HLU = 6'b110010;
  localparam logic [5:0] HBR = 6'b000110;
  localparam logic [5:0] HFZ = 6'b111000;
  localparam logic [5:0] HTO = 6'b111001;

  localparam logic [31:0] LW_X5       = 32'h0000A283;
  localparam logic [31:0] LW_X0       = 32'h0000A003;
  localparam logic [31:0] ADD_X6_X5X1 = 32'h00128333;
  localparam logic [31:0] ADD_X6_X0X1 = 32'h00100333;
  localparam logic [31:0] ADDI_X7_X0  = 32'h00500393;
  localparam logic [31:0] SW_X5       = 32'h0050A023;
  localparam logic [31:0] BEQ_X1X2    = 32'h00208063;
  localparam logic [31:0] ILLEGAL     = 32'h0000007F;
  localparam logic [31:0] NOP_BITS    = 32'h00000000;

  typedef struct packed {
    logic [7:0] ctrl;
    logic [5:0] haz;
  } exp_t;

  exp_t             expQ[$];
  string            tagQ[$];
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] expStall = '0;
  logic [CNT_W-1:0] expFlush = '0;

  task automatic applyStimulus(input string tag, input logic [31:0] instr,
                               input logic v, input logic bt, input logic req,
                               input logic rdy, input logic [7:0] ctrl,
                               input logic [5:0] haz);
    exp_t e;
    instr_d        = instr;
    valid_d        = v;
    branch_taken_e = bt;
    mem_req_m      = req;
    mem_ready      = rdy;
    e.ctrl = ctrl;
    e.haz  = haz;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t             e;
    string            t;
    logic [7:0]       oc;
    logic [5:0]       oh;
    logic [CNT_W-1:0] es;
    logic [CNT_W-1:0] ef;
    checks++;
    assert (expQ.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (expQ.size() == 0) return;
    e  = expQ.pop_front();
    t  = tagQ.pop_front();
    oc = {imm_src_d, reg_write_d, mem_read_d, mem_write_d, branch_d, alu_src_d, illegal_d};
    oh = {stall_f, stall_d, stall_em, flush_d, flush_e, mem_timeout};
    es = PERF_EN ? expStall : '0;
    ef = PERF_EN ? expFlush : '0;
    checks++;
    assert (oc === e.ctrl) else begin
      failures++;
      $error("[TB] FAIL %s.ctrl observed=%b expected=%b", t, oc, e.ctrl);
    end
    checks++;
    assert (oh === e.haz) else begin
      failures++;
      $error("[TB] FAIL %s.haz observed=%b expected=%b", t, oh, e.haz);
    end
    checks++;
    assert (stall_cnt === es) else begin
      failures++;
      $error("[TB] FAIL %s.stall_cnt observed=%0d expected=%0d", t, stall_cnt, es);
    end
    checks++;
    assert (flush_cnt === ef) else begin
      failures++;
      $error("[TB] FAIL %s.flush_cnt observed=%0d expected=%0d", t, flush_cnt, ef);
    end
    expStall = expStall + CNT_W'(e.haz[5]);
    expFlush = expFlush + CNT_W'(e.haz[1]);
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic v,
                      input logic bt, input logic req, input logic rdy,
                      input logic [7:0] ctrl, input logic [5:0] haz);
    applyStimulus(tag, instr, v, bt, req, rdy, ctrl, haz);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus("reset", NOP_BITS, 1'b0, 1'b0, 1'b0, 1'b0, C0, H0);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // load-use on rs1, then the held instruction flows
    step("lw_x5",        LW_X5,       1, 0, 0, 0, CLD, H0);
    step("lu_stall",     ADD_X6_X5X1, 1, 0, 0, 0, CR,  HLU);
    step("lu_flow",      ADD_X6_X5X1, 1, 0, 0, 0, CR,  H0);
    step("lw_x0",        LW_X0,       1, 0, 0, 0, CLD, H0);
    step("x0_nostall",   ADD_X6_X0X1, 1, 0, 0, 0, CR,  H0);
    // I-type does not use the rs2 field even when it matches
    step("lw_x5_b",      LW_X5,       1, 0, 0, 0, CLD, H0);
    step("addi_rs2fld",  ADDI_X7_X0,  1, 0, 0, 0, CI,  H0);
    step("lw_x5_c",      LW_X5,       1, 0, 0, 0, CLD, H0);
    step("sw_rs2_stall", SW_X5,       1, 0, 0, 0, CST, HLU);
    // branch wins over a simultaneous load-use
    step("lw_x5_d",      LW_X5,       1, 0, 0, 0, CLD, H0);
    step("br_over_lu",   ADD_X6_X5X1, 1, 1, 0, 0, CR,  HBR);
    // a bubble carrying load bits leaves no hazard behind
    step("lw_invalid",   LW_X5,       0, 0, 0, 0, C0,  H0);
    step("inval_nolu",   ADD_X6_X5X1, 1, 0, 0, 0, CR,  H0);
    step("beq",          BEQ_X1X2,    1, 0, 0, 0, CBR, H0);
    step("illegal",      ILLEGAL,     1, 0, 0, 0, CIL, H0);
    // freeze overrides branch and load-use; EX tracker holds through it
    step("lw_pre_mem",   LW_X5,       1, 0, 0, 0, CLD, H0);
    step("mem_run_frz",  ADD_X6_X5X1, 1, 1, 1, 0, CR,  HFZ);
    step("mem_wait1",    ADD_X6_X5X1, 1, 1, 1, 0, CR,  HFZ);
    step("mem_wait2",    ADD_X6_X5X1, 1, 1, 1, 0, CR,  HFZ);
    step("mem_done",     ADD_X6_X5X1, 1, 1, 1, 1, CR,  HFZ);
    step("after_mem",    ADD_X6_X5X1, 1, 0, 0, 0, CR,  HLU);
    // forced exit on the 16th MEM_WAIT cycle
    step("to_run",       NOP_BITS,    0, 0, 1, 0, C0,  HFZ);
    for (int k = 1; k <= 16; k++) begin
      step((k == 16) ? "to_fire" : "to_wait", NOP_BITS, 0, 0, 1, 0, C0,
           (k == 16) ? HTO : HFZ);
    end
    step("after_to",     NOP_BITS,    0, 0, 0, 0, C0,  H0);
    // reset while in MEM_WAIT
    step("mw_a",         NOP_BITS,    0, 0, 1, 0, C0,  HFZ);
    step("mw_b",         NOP_BITS,    0, 0, 1, 0, C0,  HFZ);
    step("mw_c",         NOP_BITS,    0, 0, 1, 0, C0,  HFZ);
    rst_n    = 1'b0;
    expStall = '0;
    expFlush = '0;
    applyStimulus("rst_mid", NOP_BITS, 1'b0, 1'b0, 1'b0, 1'b0, C0, H0);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst",     NOP_BITS,    0, 0, 1, 1, C0,  H0);
    step("post_rst2",    NOP_BITS,    0, 0, 0, 0, C0,  H0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
